// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: controller state encoding,
// UART frame constants and the default serializer timing.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_FRAME_BITS = 10;
    localparam int   UART_CLOCK_FREQ = 50_000_000;
    localparam int   UART_BAUD       = 9600;

    // Round-robin successor of a requester index.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index scanning from rr_ptr upward,
// wrapping modulo NUM_REQ. Reusable for any valid-vector arbitration.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the scan, so no path can infer a latch.
        winner     = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && valid[idx]) begin
                any_valid   = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte-stream requesters, granting it for
// a whole packet in round-robin order and flagging a serializer that never goes busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BUSY_WAIT_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 active,
    output logic                 err
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 1);

    state_t               state;
    state_t               state_nx;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic                 last_q;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 arb_go;
    logic                 owner_valid;
    logic                 busy_timeout;
    logic [PTR_W-1:0]     ptr_after_owner;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid      (req_valid),
        .rr_ptr     (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_valid  (pick_any)
    );

    assign arb_go          = pick_any && !tx_busy;
    assign owner_valid     = req_valid[owner];
    assign busy_timeout    = !tx_busy && (wait_cnt == WAIT_W'(BUSY_WAIT_MAX - 1));
    assign ptr_after_owner = PTR_W'(wrap_inc(int'(owner), NUM_REQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (arb_go) state_nx = ST_SEND;
            ST_SEND:    if (owner_valid) state_nx = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_busy)           state_nx = ST_WAIT_LO;
                else if (busy_timeout) state_nx = ST_IDLE;
            end
            ST_WAIT_LO: if (!tx_busy) state_nx = last_q ? ST_IDLE : ST_SEND;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Registered datapath: grant, byte capture, start pulse, busy watchdog, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            last_q   <= 1'b0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge register values.
            tx_start <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_go) begin
                        grant <= pick_onehot;
                        owner <= pick_idx;
                    end
                end
                ST_SEND: begin
                    if (owner_valid) begin
                        tx_data  <= req_data[{owner, 3'b000} +: 8];
                        tx_start <= 1'b1;
                        last_q   <= req_last[owner];
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (busy_timeout) begin
                        err    <= 1'b1;
                        grant  <= '0;
                        rr_ptr <= ptr_after_owner;
                    end else if (!tx_busy) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy && last_q) begin
                        grant  <= '0;
                        rr_ptr <= ptr_after_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        active    = (state != ST_IDLE);
        req_ready = (state == ST_SEND) ? grant : '0;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a
// uart_tx model answers tx_start, and a scoreboard checks each byte and its grant.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [7:0]   data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           active;
    logic           err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int err_count = 0;
    int busy_cnt = 0;
    logic model_dead = 1'b0;
    logic [N-1:0] hold = '0;
    logic [N-1:0] fire;
    logic prev_start = 1'b0;

    logic [8:0] src_q [N][$];
    exp_t       exp_q [$];

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .active    (active),
        .err       (err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Queue a byte at a requester and the scoreboard entry it should produce.
    task automatic load(input int r, input logic [7:0] d, input logic last, input logic [N-1:0] g);
        exp_t e;
        src_q[r].push_back({last, d});
        e.grant = g;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (!(exp_q.size() == 0 && !active && srcs_empty()) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < max_cyc), 32'd1);
    endtask

    // Requesters: present the head of each queue, pop it after a valid&&ready edge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !hold[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // uart_tx model: busy rises one cycle after a start pulse and stays high 20 cycles.
    initial begin
        logic st;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else begin
                st = tx_start;
                #1;
                if (st && !model_dead) busy_cnt = 20;
                else if (busy_cnt > 0) busy_cnt--;
                tx_busy = (busy_cnt != 0);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                check("start_one_cycle", 32'(prev_start), 32'd0);
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("grant_at_start", 32'(grant), 32'(e.grant));
                end
                start_cyc = cyc;
            end
            if (rst_n && err) err_count++;
            prev_start = tx_start;
        end
    end

    initial begin
        int n;
        logic saw_start;
        logic grant_moved;

        #1 rst_n = 1'b0;
        #2;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single two-byte packet from requester 2; leaves rr_ptr at 3.
        load(2, 8'h41, 1'b0, 4'b0100);
        load(2, 8'h42, 1'b1, 4'b0100);
        wait_done("single_done", 200);
        check("single_grant_idle", 32'(grant), 32'd0);

        // rr_ptr==3 means requester 3 beats requester 0.
        load(3, 8'h13, 1'b1, 4'b1000);
        load(0, 8'h10, 1'b1, 4'b0001);
        wait_done("ptr3_done", 200);
        load(3, 8'h33, 1'b1, 4'b1000);
        wait_done("solo3_done", 200);

        // All four valid with rr_ptr==0.
        load(0, 8'h50, 1'b1, 4'b0001);
        load(1, 8'h51, 1'b1, 4'b0010);
        load(2, 8'h52, 1'b1, 4'b0100);
        load(3, 8'h53, 1'b1, 4'b1000);
        wait_done("rr_done", 400);

        // Three-byte packet from 0 is not interleaved with requester 1.
        load(0, 8'h60, 1'b0, 4'b0001);
        load(0, 8'h61, 1'b0, 4'b0001);
        load(0, 8'h62, 1'b1, 4'b0001);
        load(1, 8'h70, 1'b1, 4'b0010);
        wait_done("atomic_done", 400);

        load(0, 8'h80, 1'b1, 4'b0001);
        wait_done("solo0_done", 200);

        // Serializer never goes busy on requester 1's byte; requester 2 follows.
        model_dead = 1'b1;
        load(1, 8'h90, 1'b1, 4'b0010);
        load(2, 8'h92, 1'b1, 4'b0100);
        n = 0;
        while (!err && n < 100) begin @(negedge clk); n++; end
        check("timeout_err_seen", 32'(err), 32'd1);
        if (err) begin
            check("timeout_err_delay", 32'(cyc - start_cyc), 32'd4);
            check("timeout_grant_clear", 32'(grant), 32'd0);
            check("timeout_active", 32'(active), 32'd0);
        end
        model_dead = 1'b0;
        wait_done("timeout_next_done", 200);

        // Reset during WAIT_LO of requester 3's first byte.
        load(3, 8'h77, 1'b0, 4'b1000);
        load(3, 8'h78, 1'b1, 4'b1000);
        n = 0;
        while (!tx_busy && n < 100) begin @(negedge clk); n++; end
        check("reset_busy_seen", 32'(tx_busy), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        src_q[3].delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(0, 8'h66, 1'b1, 4'b0001);
        load(3, 8'h55, 1'b1, 4'b1000);
        wait_done("post_reset_done", 200);

        // Owner stalls between bytes for 100 cycles.
        load(0, 8'hA0, 1'b0, 4'b0001);
        load(0, 8'hA1, 1'b1, 4'b0001);
        n = 0;
        while (!tx_start && n < 100) begin @(negedge clk); n++; end
        check("stall_first_start", 32'(tx_start), 32'd1);
        hold[0] = 1'b1;
        saw_start   = 1'b0;
        grant_moved = 1'b0;
        repeat (100) begin
            @(negedge clk);
            saw_start   = saw_start | tx_start;
            grant_moved = grant_moved | (grant != 4'b0001);
        end
        check("stall_no_start", 32'(saw_start), 32'd0);
        check("stall_grant_held", 32'(grant_moved), 32'd0);
        check("stall_ready_no_valid", 32'(req_ready), 32'(4'b0001));
        check("stall_active", 32'(active), 32'd1);
        hold[0] = 1'b0;
        wait_done("stall_done", 200);

        check("err_pulse_count", 32'(err_count), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
